// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: drives the PC, IF/ID and ID/EX enables and flushes
// from data/instruction wait, multi-cycle MDU ops, branch redirects and load-use hazards.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_BITS = 5,
  parameter int unsigned MDU_LAT       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     im_stall,
  input  logic                     dm_stall,
  input  logic [REG_ADDR_BITS-1:0] id_rs1_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rs2_addr,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_ADDR_BITS-1:0] ex_rd_addr,
  input  logic                     ex_mem_read,
  input  logic                     ex_branch_taken,
  input  logic                     ex_mdu_start,
  output logic                     PC_Write,
  output logic                     IF_reg_Write,
  output logic                     IF_flush,
  output logic                     ID_flush,
  output logic                     stall_all
);

  localparam int unsigned CW = $clog2(MDU_LAT);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] MDU_BUSY   = 2'd1;
  localparam logic [1:0] FLUSH_WAIT = 2'd2;

  localparam logic [CW-1:0] MDU_RELOAD = CW'(MDU_LAT - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] mdu_cnt;
  logic          freeze;
  logic          load_use;

  assign freeze   = dm_stall | (state == MDU_BUSY);
  assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    PC_Write     = 1'b0;
    IF_reg_Write = 1'b0;
    IF_flush     = 1'b0;
    ID_flush     = 1'b0;
    stall_all    = 1'b0;
    if (!rst) begin
      // all outputs held low during reset
    end else if (freeze) begin
      stall_all = 1'b1;
    end else if (state == FLUSH_WAIT) begin
      // Wrong-path word is squashed into a NOP when it finally returns; PC already holds the target.
      ID_flush     = 1'b1;
      IF_flush     = !im_stall;
      IF_reg_Write = !im_stall;
    end else if (ex_branch_taken) begin
      PC_Write     = 1'b1;
      IF_reg_Write = 1'b1;
      IF_flush     = 1'b1;
      ID_flush     = 1'b1;
    end else if (im_stall || load_use) begin
      ID_flush = 1'b1;
    end else begin
      PC_Write     = 1'b1;
      IF_reg_Write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!dm_stall) begin
            if (ex_mdu_start) begin
              state   <= MDU_BUSY;
              mdu_cnt <= MDU_RELOAD;
            end else if (ex_branch_taken && im_stall) begin
              state <= FLUSH_WAIT;
            end
          end
        end
        MDU_BUSY: begin
          mdu_cnt <= mdu_cnt - CNT_LAST;
          if (mdu_cnt == CNT_LAST) state <= RUN;
        end
        FLUSH_WAIT: begin
          if (!dm_stall && !im_stall) state <= RUN;
        end
        default: begin
          state   <= RUN;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle behavioural model checked on every negedge,
// plus hand-computed literal expectations at key points of each scenario.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RAB = 5;
  localparam int unsigned LAT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           im_stall, dm_stall;
  logic [RAB-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic           id_rs1_used, id_rs2_used;
  logic           ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic           PC_Write, IF_reg_Write, IF_flush, ID_flush, stall_all;

  int checks = 0;
  int errors = 0;

  // model state: remaining frozen MDU cycles, and whether a wrong-path fetch awaits squashing
  int   mdu_left = 0;
  logic squash_pending = 1'b0;

  pipe_hazard_ctrl #(.REG_ADDR_BITS(RAB), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .im_stall(im_stall), .dm_stall(dm_stall),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .PC_Write(PC_Write), .IF_reg_Write(IF_reg_Write), .IF_flush(IF_flush),
    .ID_flush(ID_flush), .stall_all(stall_all)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {PC_Write, IF_reg_Write, IF_flush, ID_flush, stall_all};
  endfunction

  // expected {PC_Write, IF_reg_Write, IF_flush, ID_flush, stall_all}
  function automatic logic [4:0] model_exp();
    logic hazard;
    hazard = ex_mem_read && ex_rd_addr != 0 &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
              (id_rs2_used && id_rs2_addr == ex_rd_addr));
    if (!rst)                      return 5'b00000;
    if (dm_stall || mdu_left > 0)  return 5'b00001;
    if (squash_pending)            return im_stall ? 5'b00010 : 5'b01110;
    if (ex_branch_taken)           return 5'b11110;
    if (im_stall || hazard)        return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      mdu_left       = 0;
      squash_pending = 1'b0;
    end else if (mdu_left > 0) begin
      mdu_left = mdu_left - 1;
    end else if (!dm_stall) begin
      if (squash_pending) begin
        if (!im_stall) squash_pending = 1'b0;
      end else if (ex_mdu_start) begin
        mdu_left = LAT - 1;
      end else if (ex_branch_taken && im_stall) begin
        squash_pending = 1'b1;
      end
    end
  end

  always @(negedge clk) check("model", outs(), model_exp());

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    im_stall = 0; dm_stall = 0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd_addr = '0; ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_start = 0;
  endtask

  task automatic lit(input string name, input logic [4:0] exp);
    #1;
    check(name, outs(), exp);
  endtask

  task automatic lw_x5_add_x6_x5_x1();
    ex_mem_read = 1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_rs1_used = 1; id_rs2_addr = 5'd1; id_rs2_used = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    step(2);
    lit("reset_idle", 5'b00000);
    dm_stall = 1; ex_branch_taken = 1;
    lit("reset_hazards", 5'b00000);
    step(1);
    idle();
    rst = 1;
    lit("normal", 5'b11000);
    step(3);

    lw_x5_add_x6_x5_x1();
    lit("loaduse_rs1", 5'b00010);
    step(1);
    ex_mem_read = 0;
    lit("loaduse_one_bubble", 5'b11000);
    step(1);
    lw_x5_add_x6_x5_x1(); ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    lit("loaduse_x0", 5'b11000);
    step(1);
    lw_x5_add_x6_x5_x1(); id_rs1_used = 0;
    lit("loaduse_unused", 5'b11000);
    step(1);
    lw_x5_add_x6_x5_x1(); id_rs1_addr = 5'd7; id_rs2_addr = 5'd5;
    lit("loaduse_rs2", 5'b00010);
    step(1);
    idle();

    ex_branch_taken = 1; im_stall = 1;
    lit("branch_imstall", 5'b11110);
    step(1);
    ex_branch_taken = 0;
    lit("flush_wait_1", 5'b00010);
    step(1);
    lit("flush_wait_2", 5'b00010);
    step(1);
    im_stall = 0;
    lit("flush_wait_squash", 5'b01110);
    step(1);
    lit("after_flush_wait", 5'b11000);
    step(1);

    ex_mdu_start = 1;
    lit("mdu_start_cycle", 5'b11000);
    step(1);
    ex_mdu_start = 0;
    lit("mdu_busy_1", 5'b00001);
    step(1);
    dm_stall = 1;
    lit("mdu_busy_2_dm", 5'b00001);
    step(1);
    lit("mdu_busy_3_dm", 5'b00001);
    step(1);
    dm_stall = 0;
    lit("mdu_not_extended", 5'b11000);
    step(1);

    dm_stall = 1; ex_mdu_start = 1;
    lit("mdu_start_under_dm", 5'b00001);
    step(2);
    dm_stall = 0;
    lit("mdu_start_after_dm", 5'b11000);
    step(1);
    ex_mdu_start = 0;
    step(3);
    lit("mdu_after_deferred", 5'b11000);
    step(1);

    dm_stall = 1; ex_branch_taken = 1; lw_x5_add_x6_x5_x1();
    lit("prio_freeze", 5'b00001);
    step(1);
    dm_stall = 0;
    lit("prio_branch_wins", 5'b11110);
    step(1);
    idle();

    ex_branch_taken = 1; im_stall = 1;
    step(1);
    ex_branch_taken = 0; im_stall = 0; dm_stall = 1;
    lit("flush_wait_dm_freeze", 5'b00001);
    step(1);
    dm_stall = 0;
    lit("flush_wait_kept", 5'b01110);
    step(1);

    ex_mdu_start = 1;
    step(1);
    ex_mdu_start = 0;
    rst = 0;
    lit("reset_mid_mdu", 5'b00000);
    step(1);
    rst = 1;
    lit("run_after_mdu_reset", 5'b11000);
    step(1);
    ex_branch_taken = 1; im_stall = 1;
    step(1);
    ex_branch_taken = 0;
    rst = 0;
    step(1);
    rst = 1; im_stall = 0;
    lit("run_after_fw_reset", 5'b11000);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
